pattern_tx: RTL and testbench

Serial pattern transmitter: captures a WIDTH-bit pattern and repeat count on a start request, then drives the pattern MSB-first onto a single-bit serial line, one bit per clock, repeated back-to-back. It is the stimulus/transmit end of the team's serial sequence-detector links. Its `output_signal` feeds a detector's `input_signal` directly. A busy/done handshake reports progress to the controlling logic.

---
 rtl/pattern_tx_pkg.sv | 11 +
 rtl/pattern_tx_shreg.sv | 35 +++
 rtl/pattern_tx.sv | 153 +++++++++++++++
 tb/tb_pattern_tx.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/pattern_tx_pkg.sv
// rtl/pattern_tx_pkg.sv - shared FSM state type and encodings for pattern_tx
package pattern_tx_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'b00;
  localparam state_t ST_SHIFT  = 2'b01;
  localparam state_t ST_PARITY = 2'b10;
  localparam state_t ST_DONE   = 2'b11;

endpackage

// File: rtl/pattern_tx_shreg.sv
// rtl/pattern_tx_shreg.sv - loadable rotate-left register with MSB output
module pattern_tx_shreg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = din;
    end else if (shift) begin
      data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign msb = data_q[WIDTH-1];

endmodule

// File: rtl/pattern_tx.sv
// rtl/pattern_tx.sv - serial MSB-first pattern transmitter with repeat count
// Optional trailing even-parity bit per repetition: PATTERN_TX_PARITY_EN.
module pattern_tx #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  output logic             output_signal,
  output logic             busy,
  output logic             done
);

  import pattern_tx_pkg::*;

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             out_q, out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             load_en;
  logic             shift_en;
  logic             shreg_msb;
  logic             rep_last;
  logic [CNT_W-1:0] cnt_dec;

  // The output flop takes the pattern MSB straight from the input on start,
  // so the register is loaded one rotation ahead and its MSB is always the next bit.
  pattern_tx_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk   (clk),
    .reset (reset),
    .load  (load_en),
    .shift (shift_en),
    .din   ({pattern[WIDTH-2:0], pattern[WIDTH-1]}),
    .msb   (shreg_msb)
  );

  assign rep_last = (cnt_q == CNT_W'(1));
  assign cnt_dec  = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;

`ifdef PATTERN_TX_PARITY_EN
  logic parity_q, parity_d;

  assign parity_d = load_en ? ^pattern : parity_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    out_d    = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    load_en  = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          load_en = 1'b1;
          cnt_d   = (repeat_cnt == '0) ? CNT_W'(1) : repeat_cnt;
          idx_d   = '0;
          out_d   = pattern[WIDTH-1];
          busy_d  = 1'b1;
        end
      end
      ST_SHIFT: begin
        busy_d   = 1'b1;
        out_d    = shreg_msb;
        shift_en = 1'b1;
        if (idx_q == IDX_LAST) begin
          idx_d = '0;
`ifdef PATTERN_TX_PARITY_EN
          state_d  = ST_PARITY;
          shift_en = 1'b0;
          out_d    = parity_q;
`else
          cnt_d = cnt_dec;
          if (rep_last) begin
            state_d  = ST_DONE;
            busy_d   = 1'b0;
            out_d    = 1'b0;
            done_d   = 1'b1;
            shift_en = 1'b0;
          end
`endif
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
`ifdef PATTERN_TX_PARITY_EN
      ST_PARITY: begin
        cnt_d    = cnt_dec;
        busy_d   = 1'b1;
        out_d    = shreg_msb;
        shift_en = 1'b1;
        state_d  = ST_SHIFT;
        if (rep_last) begin
          state_d  = ST_DONE;
          busy_d   = 1'b0;
          out_d    = 1'b0;
          done_d   = 1'b1;
          shift_en = 1'b0;
        end
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign output_signal = out_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_pattern_tx.sv
// tb/tb_pattern_tx.sv - self-checking bench for pattern_tx against a bit-queue model
module tb_pattern_tx;

  localparam int WIDTH = 4;
  localparam int CNT_W = 4;
`ifdef PATTERN_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [CNT_W-1:0] repeat_cnt;
  logic             output_signal;
  logic             busy;
  logic             done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pattern_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .pattern       (pattern),
    .repeat_cnt    (repeat_cnt),
    .output_signal (output_signal),
    .busy          (busy),
    .done          (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected serial stream: R copies of the pattern MSB-first, each followed by parity when enabled.
  task automatic build_stream(input logic [WIDTH-1:0] pat, input logic [CNT_W-1:0] rc,
                              output logic q[$]);
    int r;
    q = {};
    r = (rc == 0) ? 1 : int'(rc);
    for (int k = 0; k < r; k++) begin
      for (int i = WIDTH - 1; i >= 0; i--) q.push_back(pat[i]);
      for (int p = 0; p < P; p++) q.push_back(^pat);
    end
  endtask

  // Called just after a negedge in a cycle where the DUT is idle.
  // noise: 0 = quiet inputs, 1 = start held high throughout, 2 = random start/pattern/count.
  task automatic xfer(input logic [WIDTH-1:0] pat, input logic [CNT_W-1:0] rc, input int noise);
    logic exp_q[$];
    int   n;
    build_stream(pat, rc, exp_q);
    n          = exp_q.size();
    start      = 1'b1;
    pattern    = pat;
    repeat_cnt = rc;
    @(posedge clk);
    for (int c = 1; c <= n + 1; c++) begin
      @(negedge clk);
      start = (noise == 1) ? 1'b1 : (noise == 2) ? 1'($urandom) : 1'b0;
      if (noise != 0) begin
        pattern    = WIDTH'($urandom);
        repeat_cnt = CNT_W'($urandom);
      end
      if (c <= n) begin
        chk($sformatf("bit p=%b r=%0d c=%0d", pat, rc, c), output_signal, exp_q[c-1]);
        chk($sformatf("busy c=%0d", c), busy, 1);
        chk($sformatf("done_early c=%0d", c), done, 0);
      end else begin
        chk("out_in_done", output_signal, 0);
        chk("busy_in_done", busy, 0);
        chk($sformatf("done_pulse p=%b r=%0d", pat, rc), done, 1);
      end
    end
    @(negedge clk);
    start = 1'b0;
    chk("idle_out", output_signal, 0);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
  endtask

  initial begin
    logic rst_q[$];
    logic [WIDTH-1:0] pr;
    logic [CNT_W-1:0] cr;

    reset      = 1'b1;
    start      = 1'b0;
    pattern    = '0;
    repeat_cnt = '0;
    repeat (3) @(negedge clk);
    chk("reset_out", output_signal, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    reset = 1'b0;
    @(negedge clk);

    xfer(4'b1011, 4'd1, 0);
    xfer(4'b1011, 4'd2, 0);
    xfer(4'b0110, 4'd0, 0);
    xfer(4'b1011, 4'd1, 1);
    xfer(4'b1001, 4'd15, 0);
    for (int t = 0; t < 10; t++) begin
      pr = WIDTH'($urandom);
      cr = CNT_W'($urandom);
      xfer(pr, cr, 2);
    end

    // Abort mid-transfer; start is also high with reset to show reset wins.
    build_stream(4'b1011, 4'd3, rst_q);
    start      = 1'b1;
    pattern    = 4'b1011;
    repeat_cnt = 4'd3;
    @(posedge clk);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("pre_reset_bit c=%0d", c), output_signal, rst_q[c-1]);
    end
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    chk("abort_out", output_signal, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      chk($sformatf("abort_no_done c=%0d", c), done, 0);
      chk($sformatf("abort_no_busy c=%0d", c), busy, 0);
    end
    xfer(4'b1011, 4'd1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
